// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared opcode values, ALU add code, one-hot step encoding and
//                opcode-class helpers for the Mini SRC control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int            OPW    = 5;
   localparam logic [OPW-1:0] ADD_OP = 5'b00011;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_OR   = 5'b01010;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
   localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
   localparam logic [OPW-1:0] OP_BR   = 5'b10010;
   localparam logic [OPW-1:0] OP_JR   = 5'b10011;
   localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
   localparam logic [OPW-1:0] OP_IN   = 5'b10101;
   localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
   localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
   localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
   localparam logic [OPW-1:0] OP_HALT = 5'b11010;

   // One-hot step encoding
   typedef enum logic [8:0] {
      ST_T0   = 9'b0_0000_0001,
      ST_T1   = 9'b0_0000_0010,
      ST_T2   = 9'b0_0000_0100,
      ST_T3   = 9'b0_0000_1000,
      ST_T4   = 9'b0_0001_0000,
      ST_T5   = 9'b0_0010_0000,
      ST_T6   = 9'b0_0100_0000,
      ST_T7   = 9'b0_1000_0000,
      ST_HALT = 9'b1_0000_0000
   } state_t;

   // Instruction families sharing one execute sequence
   typedef enum logic [3:0] {
      C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LDI, C_LD, C_ST, C_BR,
      C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } op_class_t;

   function automatic op_class_t classify(input logic [OPW-1:0] op);
      op_class_t c;
      c = C_NOP;
      if (op == OP_LD)                         c = C_LD;
      else if (op == OP_LDI)                   c = C_LDI;
      else if (op == OP_ST)                    c = C_ST;
      else if (op >= OP_ADD  && op <= OP_OR)   c = C_ALU3;
      else if (op >= OP_ADDI && op <= OP_ORI)  c = C_IMM;
      else if (op == OP_MUL  || op == OP_DIV)  c = C_MULDIV;
      else if (op == OP_NEG  || op == OP_NOT)  c = C_UNARY;
      else if (op == OP_BR)                    c = C_BR;
      else if (op == OP_JR)                    c = C_JR;
      else if (op == OP_JAL)                   c = C_JAL;
      else if (op == OP_IN)                    c = C_IN;
      else if (op == OP_OUT)                   c = C_OUT;
      else if (op == OP_MFHI)                  c = C_MFHI;
      else if (op == OP_MFLO)                  c = C_MFLO;
      else if (op == OP_HALT)                  c = C_HALT;
      return c;
   endfunction

   // Final execute step of each family; stop is honoured when leaving it
   function automatic state_t last_step(input op_class_t c);
      state_t s;
      case (c)
         C_ALU3, C_IMM, C_LDI:   s = ST_T5;
         C_MULDIV, C_BR:         s = ST_T6;
         C_UNARY, C_JAL:         s = ST_T4;
         C_LD, C_ST:             s = ST_T7;
         default:                s = ST_T3;
      endcase
      return s;
   endfunction

   // Execute steps that hold until memory reports completion
   function automatic logic mem_wait(input state_t s, input op_class_t c);
      return ((c == C_LD) && (s == ST_T6)) || ((c == C_ST) && (s == ST_T7));
   endfunction

   function automatic state_t next_step(input state_t s);
      state_t n;
      case (s)
         ST_T3:   n = ST_T4;
         ST_T4:   n = ST_T5;
         ST_T5:   n = ST_T6;
         ST_T6:   n = ST_T7;
         default: n = ST_T0;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : control_unit_if
//  Description : Datapath-facing bundle of the control unit: IR / CON FF /
//                memory handshake inputs and every control strobe.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
   import cpu_pkg::*;

   logic [31:0]    ir;
   logic           con_ff;
   logic           mem_ready;
   logic           stop;

   logic           Gra, Grb, Grc, Rin, Rout, BAout;
   logic           PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
   logic           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin;
   logic           IncPC, Read, Write;
   logic [OPW-1:0] alu_op;
   logic           run;

   modport master (
      input  ir, con_ff, mem_ready, stop,
      output Gra, Grb, Grc, Rin, Rout, BAout,
      output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
      output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin,
      output IncPC, Read, Write, alu_op, run
   );

   modport slave (
      output ir, con_ff, mem_ready, stop,
      input  Gra, Grb, Grc, Rin, Rout, BAout,
      input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
      input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OutPortin,
      input  IncPC, Read, Write, alu_op, run
   );

endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Multi-cycle Moore sequencer for the Mini SRC datapath.
//                Fetch T0-T2, opcode-driven execute T3-T7, HALT state.
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit
   import cpu_pkg::*;
(
   input  wire logic      clock,
   input  wire logic      clear,
   control_unit_if.master bus
);

   state_t         state_q;
   logic [OPW-1:0] opcode_q;
   logic           t1_hold_q;   // set while T1 is repeating, so PCin fires once

   op_class_t      w_cls;
   op_class_t      w_cls_ir;
   logic           w_active;
   logic           w_unused;

   assign w_cls    = classify(opcode_q);
   assign w_cls_ir = classify(bus.ir[31:27]);
   assign w_unused = ^bus.ir[26:0];

   // Step sequencing, opcode latch and T1 repeat tracking
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q   <= ST_T0;
         opcode_q  <= '0;
         t1_hold_q <= 1'b0;
      end else begin
         t1_hold_q <= 1'b0;
         case (state_q)
            ST_T0: state_q <= ST_T1;
            ST_T1: begin
               if (bus.mem_ready) state_q   <= ST_T2;
               else               t1_hold_q <= 1'b1;
            end
            ST_T2: begin
               opcode_q <= bus.ir[31:27];
               if (w_cls_ir == C_HALT)      state_q <= ST_HALT;
               else if (w_cls_ir == C_NOP)  state_q <= bus.stop ? ST_HALT : ST_T0;
               else                         state_q <= ST_T3;
            end
            ST_HALT: state_q <= ST_HALT;
            default: begin
               if (mem_wait(state_q, w_cls) && !bus.mem_ready)
                  state_q <= state_q;
               else if (state_q == last_step(w_cls))
                  state_q <= bus.stop ? ST_HALT : ST_T0;
               else
                  state_q <= next_step(state_q);
            end
         endcase
      end
   end

   // Strobes are silent during reset and in HALT
   assign w_active = clear && (state_q != ST_HALT);

   // Decode of current step and latched opcode into control strobes
   always_comb begin
      bus.Gra = 1'b0;  bus.Grb = 1'b0;  bus.Grc = 1'b0;
      bus.Rin = 1'b0;  bus.Rout = 1'b0; bus.BAout = 1'b0;
      bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
      bus.HIout = 1'b0; bus.LOout = 1'b0;   bus.InPortout = 1'b0; bus.Cout = 1'b0;
      bus.PCin = 1'b0; bus.IRin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0;
      bus.Yin = 1'b0;  bus.Zin = 1'b0;  bus.HIin = 1'b0;  bus.LOin = 1'b0;
      bus.CONin = 1'b0; bus.OutPortin = 1'b0;
      bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
      bus.alu_op = '0;
      bus.run = w_active;
      if (w_active) begin
         case (state_q)
            ST_T0: begin
               bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
               bus.Zin = 1'b1;   bus.alu_op = ADD_OP;
            end
            ST_T1: begin
               bus.Zlowout = 1'b1; bus.PCin = !t1_hold_q;
               bus.Read = 1'b1;    bus.MDRin = 1'b1;
            end
            ST_T2: begin
               bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            ST_T3: begin
               case (w_cls)
                  C_ALU3, C_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                  C_MULDIV:      begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                  C_UNARY: begin
                     bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode_q;
                  end
                  C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                  C_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                  C_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                  C_JAL:  begin bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1; end
                  C_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  C_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
                  C_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  C_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  default: ;
               endcase
            end
            ST_T4: begin
               case (w_cls)
                  C_ALU3: begin
                     bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode_q;
                  end
                  C_IMM:  begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode_q; end
                  C_MULDIV: begin
                     bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = opcode_q;
                  end
                  C_UNARY: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ADD_OP; end
                  C_BR:   begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                  C_JAL:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                  default: ;
               endcase
            end
            ST_T5: begin
               case (w_cls)
                  C_ALU3, C_IMM, C_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  C_MULDIV:   begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                  C_LD, C_ST: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                  C_BR:       begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ADD_OP; end
                  default: ;
               endcase
            end
            ST_T6: begin
               case (w_cls)
                  C_MULDIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                  C_LD:     begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                  C_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                  C_BR:     begin bus.Zlowout = 1'b1; bus.PCin = bus.con_ff; end
                  default: ;
               endcase
            end
            ST_T7: begin
               case (w_cls)
                  C_LD:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  C_ST:    bus.Write = 1'b1;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
